// File: rtl/micro_processor_pkg.sv
// Shared constants for the instruction-fetch front end.
// These are the memory depth, the instruction width and the mode encodings.
package micro_processor_pkg;

  localparam int MEM_BYTES = 256;
  localparam int INSTR_W   = 32;

  localparam logic PROG_MODE = 1'b0;
  localparam logic RUN_MODE  = 1'b1;

endpackage

// File: rtl/micro_processor_instr_mem.sv
// Byte-addressed instruction RAM with a synchronous byte write and a combinational big-endian word read.
// Read latency is 0 cycles and write latency is 1 cycle; there is no backpressure.
module instr_mem
  import micro_processor_pkg::*;
#(
  parameter int DEPTH = MEM_BYTES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [7:0]         wr_dat,
  input  logic [AW-1:2]      rd_word_addr,
  output logic [INSTR_W-1:0] rd_dat
);

  // Zero-initialised so that unwritten locations fetch as 8'h00.
  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  // No reset on the array: the program survives reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // The lowest byte address lands in the MSB.
  assign rd_dat = {mem[{rd_word_addr, 2'b00}],
                   mem[{rd_word_addr, 2'b01}],
                   mem[{rd_word_addr, 2'b10}],
                   mem[{rd_word_addr, 2'b11}]};

endmodule

// File: rtl/micro_processor.sv
// Fetch front end: the program counter walks instr_mem and the fetched word is registered on each run-mode edge.
// Word n appears after run-mode edge n+1; there is no backpressure, and the output is always driven.
module micro_processor
  import micro_processor_pkg::*;
#(
  parameter int MEM_BYTES = micro_processor_pkg::MEM_BYTES,
  parameter int ADDR_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         Instruction_Data_input,
  input  logic [ADDR_W-1:0]  Instruction_Address_input,
  input  logic               En_Program,
  output logic [INSTR_W-1:0] Instruction_Data_output
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [ADDR_W-1:0]  pc;
  logic [AW-1:0]      pc_inc;
  logic [INSTR_W-1:0] fetch_dat;
  logic               wr_en;

  // Out-of-range addresses are dropped rather than aliased onto low memory.
  assign wr_en = (En_Program == PROG_MODE) &&
                 (Instruction_Address_input < ADDR_W'(MEM_BYTES));

  // Truncating to AW bits gives the wrap from MEM_BYTES-4 back to 0.
  assign pc_inc = pc[AW-1:0] + AW'(4);

  instr_mem #(
    .DEPTH (MEM_BYTES),
    .AW    (AW)
  ) u_instr_mem (
    .clk          (clk),
    .wr_en        (wr_en),
    .wr_addr      (Instruction_Address_input[AW-1:0]),
    .wr_dat       (Instruction_Data_input),
    .rd_word_addr (pc[AW-1:2]),
    .rd_dat       (fetch_dat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc                      <= '0;
      Instruction_Data_output <= '0;
    end else if (En_Program == PROG_MODE) begin
      pc                      <= '0;
      Instruction_Data_output <= '0;
    end else begin
      pc                      <= ADDR_W'(pc_inc);
      Instruction_Data_output <= fetch_dat;
    end
  end

endmodule

// File: tb/tb_micro_processor.sv
// Randomised and directed bench for micro_processor against a byte-array reference model.
module tb_micro_processor;

  localparam int MB = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din;
  logic [31:0] addr;
  logic        en;
  logic [31:0] dout;

  always #5 clk = ~clk;

  micro_processor #(.MEM_BYTES(MB), .ADDR_W(32)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .Instruction_Data_input    (din),
    .Instruction_Address_input (addr),
    .En_Program                (en),
    .Instruction_Data_output   (dout)
  );

  logic [7:0]  m_mem [MB];
  int          m_pc;
  logic [31:0] m_out;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, let the edge pass, advance the model, and compare.
  task automatic cyc(input logic rst, input logic e, input logic [31:0] a, input logic [7:0] d);
    reset = rst; en = e; addr = a; din = d;
    @(posedge clk);
    if (!e && a < MB) m_mem[a] = d;
    if (!rst || !e) begin
      m_pc  = 0;
      m_out = 32'h0;
    end else begin
      m_out = {m_mem[m_pc], m_mem[m_pc+1], m_mem[m_pc+2], m_mem[m_pc+3]};
      m_pc  = (m_pc + 4) % MB;
    end
    #1 chk("model", dout, m_out);
  endtask

  logic [7:0]  prog [16] = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h0C, 8'h0F, 8'h29, 8'hE4,
                             8'h1A, 8'h81, 8'h31, 8'hD2, 8'hD9, 8'h02, 8'h7F, 8'h51};
  logic [31:0] exp_w [5] = '{32'h00010208, 32'h0C0F29E4, 32'h1A8131D2, 32'hD9027F51, 32'h0};

  initial begin
    for (int i = 0; i < MB; i++) m_mem[i] = 8'h00;
    m_pc = 0; m_out = 0;
    reset = 1'b0; en = 1'b0; addr = 0; din = 0;
    #2 chk("reset_state", dout, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, i, prog[i]);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 0, 0);
      chk("seq_fetch", dout, exp_w[i]);
    end

    // Reset pulse between edges must clear the output without a clock.
    #2 reset = 1'b0;
    #1 chk("async_rst", dout, 32'h0);
    m_pc = 0; m_out = 0;
    cyc(1'b1, 1'b1, 0, 0);
    chk("after_rst", dout, 32'h00010208);

    cyc(1'b1, 1'b0, MB-4, 8'hAA);
    cyc(1'b1, 1'b0, MB-3, 8'hBB);
    cyc(1'b1, 1'b0, MB-2, 8'hCC);
    cyc(1'b1, 1'b0, MB-1, 8'hDD);
    for (int i = 0; i < MB/4; i++) cyc(1'b1, 1'b1, 0, 0);
    chk("last_word", dout, 32'hAABBCCDD);
    cyc(1'b1, 1'b1, 0, 0);
    chk("wrap", dout, 32'h00010208);

    cyc(1'b1, 1'b0, MB+1, 8'hFF);
    cyc(1'b1, 1'b1, 0, 0);
    chk("oob_write", dout, 32'h00010208);

    cyc(1'b1, 1'b1, 0, 0);
    cyc(1'b1, 1'b0, 0, 8'hFF);
    chk("mode_switch", dout, 32'h0);
    cyc(1'b1, 1'b1, 0, 0);
    chk("reprog", dout, 32'hFF010208);

    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, i, 8'(8'h11 * (i + 1)));
      chk("prog_in_rst", dout, 32'h0);
    end
    cyc(1'b1, 1'b1, 0, 0);
    chk("rst_write", dout, 32'h11223344);

    // Random mix of programming bursts, run stretches and occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic r, e;
      r = ($urandom_range(0, 19) != 0);
      e = ($urandom_range(0, 9) < 7);
      cyc(r, e, $urandom_range(0, MB + 15), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
